rom_reader: RTL and testbench

ROM_READER -- requirements
Module: rom_reader

---
 rtl/rom_reader.sv | 126 ++++++++++++
 tb/tb_rom_reader.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_reader.sv
// Burst reader: streams `length` consecutive ROM words from startAddr (wrapping at SIZE) onto a valid/ready port.
// Latency: start sampled at edge N -> first beat valid after edge N+1; one beat per cycle while outReady is high.
// Backpressure: outValid && !outReady holds beat, address and count stable. Optional ROM_READER_LOOP_EN replays the burst.
module rom_reader #(
    parameter int SIZE       = 16,
    parameter int DATA_WIDTH = 4,
    localparam int ADDR_WIDTH = ($clog2(SIZE) > 1) ? $clog2(SIZE) : 1,
    localparam int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] startAddr,
    input  logic [LEN_WIDTH-1:0]  length,
`ifdef ROM_READER_LOOP_EN
    input  logic                  loop,
`endif
    output logic [ADDR_WIDTH-1:0] romAddr,
    input  logic [DATA_WIDTH-1:0] romData,
    output logic                  outValid,
    input  logic                  outReady,
    output logic [DATA_WIDTH-1:0] outData,
    output logic                  outLast,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [LEN_WIDTH-1:0]   remaining;
    logic [LEN_WIDTH-1:0]   len_clamped;
    logic [ADDR_WIDTH-1:0]  next_addr;
    logic                   load;
    logic                   accept;

    assign len_clamped = (length > LEN_WIDTH'(SIZE)) ? LEN_WIDTH'(SIZE) : length;
    assign accept      = outValid && outReady;
    // A new word may enter the output register whenever it is empty or being drained this cycle.
    assign load        = (state_q == STREAM) && (remaining != '0) && (!outValid || outReady);
    assign next_addr   = (romAddr == ADDR_WIDTH'(SIZE - 1)) ? '0 : romAddr + ADDR_WIDTH'(1);

`ifdef ROM_READER_LOOP_EN
    logic [ADDR_WIDTH-1:0] saved_addr;
    logic [LEN_WIDTH-1:0]  saved_len;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            saved_addr <= '0;
            saved_len  <= '0;
        end else if (state_q == IDLE && start) begin
            saved_addr <= startAddr;
            saved_len  <= len_clamped;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = (state_q != IDLE);
        done    = (state_q == DONE);
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (len_clamped != '0) ? STREAM : DONE;
                end
            end
            STREAM: begin
                if (accept && outLast) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
`ifdef ROM_READER_LOOP_EN
                // An empty looped burst stays in DONE rather than parking in STREAM with nothing to send.
                if (loop) begin
                    state_d = (saved_len != '0) ? STREAM : DONE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            romAddr   <= '0;
            remaining <= '0;
            outData   <= '0;
            outValid  <= 1'b0;
            outLast   <= 1'b0;
        end else begin
            if (state_q == IDLE && start) begin
                romAddr   <= startAddr;
                remaining <= len_clamped;
            end
`ifdef ROM_READER_LOOP_EN
            else if (state_q == DONE && loop) begin
                romAddr   <= saved_addr;
                remaining <= saved_len;
            end
`endif
            else if (load) begin
                outData   <= romData;
                outValid  <= 1'b1;
                outLast   <= (remaining == LEN_WIDTH'(1));
                romAddr   <= next_addr;
                remaining <= remaining - LEN_WIDTH'(1);
            end else if (accept) begin
                outValid  <= 1'b0;
                outLast   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rom_reader.sv
// Bench for rom_reader: table of bursts checked through a beat scoreboard, plus reset and loop sequences.
module tb_rom_reader;

    localparam int SIZE = 16;
    localparam int DW   = 4;
    localparam int AW   = 4;
    localparam int LW   = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] startAddr;
    logic [LW-1:0] length;
    logic [AW-1:0] romAddr;
    logic [DW-1:0] romData;
    logic          outValid;
    logic          outReady;
    logic [DW-1:0] outData;
    logic          outLast;
    logic          busy;
    logic          done;
`ifdef ROM_READER_LOOP_EN
    logic          loop;
`endif

    logic [DW-1:0] rom [SIZE];
    assign romData = rom[romAddr];

    always #5 clk = ~clk;

    rom_reader #(.SIZE(SIZE), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .startAddr (startAddr),
        .length    (length),
`ifdef ROM_READER_LOOP_EN
        .loop      (loop),
`endif
        .romAddr   (romAddr),
        .romData   (romData),
        .outValid  (outValid),
        .outReady  (outReady),
        .outData   (outData),
        .outLast   (outLast),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        logic [AW-1:0] saddr;
        logic [LW-1:0] len;
        int            mode;   // 0: ready always, 1: ready toggling, 2: ready random
        bit            poke;   // drive spurious starts mid-burst
    } vec_t;

    vec_t          vecs [8];
    int            checks = 0;
    int            errors = 0;
    logic [DW:0]   sb_q [$];   // {last, data}

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, $signed(act), $signed(exp), $time);
        end
    endtask

    task automatic run_burst(input logic [AW-1:0] saddr, input logic [LW-1:0] len,
                             input int mode, input bit poke);
        int            eff;
        int            cyc;
        int            last_acc;
        int            first_vld;
        int            nbeats;
        bit            stalled;
        logic [DW-1:0] pdata;
        logic          plast;
        logic [AW-1:0] paddr;
        logic [DW:0]   e;
        eff = (int'(len) > SIZE) ? SIZE : int'(len);
        for (int i = 0; i < eff; i++) begin
            e[DW]      = (i == eff - 1);
            e[DW-1:0]  = DW'((int'(saddr) + i) % SIZE);
            sb_q.push_back(e);
        end
        last_acc  = -10;
        first_vld = -1;
        nbeats    = 0;
        stalled   = 1'b0;
        pdata     = '0;
        plast     = 1'b0;
        paddr     = '0;
        @(negedge clk);
        start     = 1'b1;
        startAddr = saddr;
        length    = len;
        outReady  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cyc = 0;
        check("busy_after_start", busy, 1);
        while (1) begin
            start = poke && (cyc < 3);
            if (poke) begin
                startAddr = 4'd9;
                length    = 5'd2;
            end
            if (stalled) begin
                check("hold_valid", outValid, 1);
                check("hold_data", outData, pdata);
                check("hold_last", outLast, plast);
                check("hold_addr", romAddr, paddr);
            end
            if (outValid && first_vld < 0) begin
                first_vld = cyc;
                check("first_beat_latency", cyc, 1);
            end
            if (done) begin
                check("done_timing", cyc, (eff == 0) ? 0 : last_acc + 1);
                check("sb_empty_at_done", sb_q.size(), 0);
                check("busy_in_done", busy, 1);
                @(negedge clk);
                check("done_one_cycle", done, 0);
                check("idle_after_done", busy, 0);
                check("no_valid_after_done", outValid, 0);
                break;
            end
            case (mode)
                0:       outReady = 1'b1;
                1:       outReady = (cyc % 2 == 0);
                default: outReady = 1'($urandom_range(0, 1));
            endcase
            if (outValid && outReady) begin
                if (sb_q.size() == 0) begin
                    check("extra_beat", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("beat_data", outData, e[DW-1:0]);
                    check("beat_last", outLast, e[DW]);
                end
                if (mode == 0) check("throughput", cyc, first_vld + nbeats);
                nbeats++;
                last_acc = cyc;
            end
            stalled = outValid && !outReady;
            pdata   = outData;
            plast   = outLast;
            paddr   = romAddr;
            if (cyc > 150) begin
                check("burst_timeout", 0, 1);
                sb_q.delete();
                break;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("beat_count", nbeats, eff);
        if (eff == 0) check("zero_len_no_valid", first_vld, -1);
    endtask

    initial begin
        for (int i = 0; i < SIZE; i++) rom[i] = DW'(i);
        rst       = 1'b1;
        start     = 1'b0;
        startAddr = '0;
        length    = '0;
        outReady  = 1'b0;
`ifdef ROM_READER_LOOP_EN
        loop      = 1'b0;
`endif
        vecs[0] = '{4'd3,  5'd4,  0, 1'b0};
        vecs[1] = '{4'd14, 5'd4,  0, 1'b0};
        vecs[2] = '{4'd3,  5'd4,  1, 1'b0};
        vecs[3] = '{4'd0,  5'd0,  0, 1'b0};
        vecs[4] = '{4'd7,  5'd20, 0, 1'b0};
        vecs[5] = '{4'd15, 5'd1,  2, 1'b0};
        vecs[6] = '{4'd0,  5'd16, 2, 1'b0};
        vecs[7] = '{4'd3,  5'd4,  0, 1'b1};

        repeat (2) @(negedge clk);
        check("rst_valid", outValid, 0);
        check("rst_data", outData, 0);
        check("rst_last", outLast, 0);
        check("rst_addr", romAddr, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 0);

        foreach (vecs[i]) run_burst(vecs[i].saddr, vecs[i].len, vecs[i].mode, vecs[i].poke);

        // Reset in the middle of a burst.
        @(negedge clk);
        start     = 1'b1;
        startAddr = 4'd3;
        length    = 5'd4;
        outReady  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("mid_beat0", outData, 3);
        @(negedge clk);
        check("mid_beat1", outData, 4);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_valid", outValid, 0);
        check("async_data", outData, 0);
        check("async_last", outLast, 0);
        check("async_addr", romAddr, 0);
        check("async_busy", busy, 0);
        check("async_done", done, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("no_done_after_rst", done, 0);
        end
        run_burst(4'd0, 5'd2, 0, 1'b0);

`ifdef ROM_READER_LOOP_EN
        begin
            int nb;
            int nd;
            logic [DW-1:0] expd;
            nb = 0;
            nd = 0;
            @(negedge clk);
            loop      = 1'b1;
            start     = 1'b1;
            startAddr = 4'd5;
            length    = 5'd2;
            outReady  = 1'b1;
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            for (int c = 0; c < 24; c++) begin
                if (outValid) begin
                    expd = (nb % 2 == 0) ? 4'd5 : 4'd6;
                    check("loop_data", outData, expd);
                    nb++;
                end
                if (done) begin
                    nd++;
                    check("loop_busy", busy, 1);
                end
                @(negedge clk);
            end
            check("loop_passes", (nd >= 3), 1);
            check("loop_beats", (nb >= 6), 1);
            loop = 1'b0;
            for (int c = 0; c < 20 && busy; c++) @(negedge clk);
            check("loop_exit_idle", busy, 0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
        $fatal(1);
    end

endmodule
